pwm_pulse_generator: RTL and testbench



---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_prescaler.sv | 40 ++++
 rtl/pwm_pulse_generator.sv | 81 ++++++++
 tb/tb_pwm_pulse_generator.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM pulse generator and upstream duty generators.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W = 6;
  localparam int unsigned PWM_STEPS = 64;
  localparam int unsigned DUTY_W    = 7;

  localparam logic [DUTY_W-1:0] DUTY_FULL = 7'd64;

  // Clamp a requested duty onto the 0..64 scale.
  function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W-1:0] d);
    return (d > DUTY_FULL) ? DUTY_FULL : d;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides sysclk into PWM count steps: tick is high on the last cycle of each step.
module pwm_prescaler #(
  parameter int unsigned PRESCALE   = 1,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [PRESCALE_W-1:0] PRE_LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] pre_cnt_q;
  logic [PRESCALE_W-1:0] pre_cnt_d;

  assign tick = (pre_cnt_q == PRE_LAST);

  // Next prescale count: held at zero while cleared, otherwise wraps on tick.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clear) begin
      pre_cnt_d = '0;
    end else if (tick) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
    end
  end

  // Prescale counter register.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_pulse_generator.sv
// 64-step PWM generator with period-boundary double-buffered duty and period-start strobe.
module pwm_pulse_generator
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE   = 1,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DUTY_W-1:0] duty_in,
  output logic              pwm_out,
  output logic              period_start,
  output logic [DUTY_W-1:0] duty_active
);

  localparam logic [PWM_CNT_W-1:0] PWM_LAST = PWM_CNT_W'(PWM_STEPS - 1);

  logic                 tick;
  logic [PWM_CNT_W-1:0] pwm_cnt_q,      pwm_cnt_d;
  logic [DUTY_W-1:0]    duty_active_q,  duty_active_d;
  logic                 pwm_out_q,      pwm_out_d;
  logic                 period_start_q, period_start_d;
  // Mirrors "prescale counter is at zero" so the strobe needs no extra prescaler port.
  logic                 pre_zero_q,     pre_zero_d;

  pwm_prescaler #(
    .PRESCALE   (PRESCALE),
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .sysclk (sysclk),
    .reset  (reset),
    .clear  (!enable),
    .tick   (tick)
  );

  // Next-state for step counter, duty buffer and registered outputs.
  always_comb begin
    pwm_cnt_d      = pwm_cnt_q;
    duty_active_d  = duty_active_q;
    pwm_out_d      = 1'b0;
    period_start_d = 1'b0;
    pre_zero_d     = 1'b1;
    if (!enable) begin
      pwm_cnt_d     = '0;
      duty_active_d = sat_duty(duty_in);
    end else begin
      pwm_out_d      = ({1'b0, pwm_cnt_q} < duty_active_q);
      period_start_d = (pwm_cnt_q == '0) && pre_zero_q;
      pre_zero_d     = tick;
      if (tick) begin
        pwm_cnt_d = pwm_cnt_q + PWM_CNT_W'(1);
        if (pwm_cnt_q == PWM_LAST) begin
          duty_active_d = sat_duty(duty_in);
        end
      end
    end
  end

  // State and output registers; reset aborts any period in progress.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      pwm_cnt_q      <= '0;
      duty_active_q  <= '0;
      pwm_out_q      <= 1'b0;
      period_start_q <= 1'b0;
      pre_zero_q     <= 1'b1;
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      duty_active_q  <= duty_active_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
      pre_zero_q     <= pre_zero_d;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign period_start = period_start_q;
  assign duty_active  = duty_active_q;

endmodule

// File: tb/tb_pwm_pulse_generator.sv
// Randomized bench: two generators (prescale 1 and 4) against a cycle-count reference model.
module tb_pwm_pulse_generator;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b0;
  logic [6:0] duty_in = 7'd32;

  logic       pwm0, ps0, pwm1, ps1;
  logic [6:0] da0, da1;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  // Reference state per instance: enabled edges since last clear, and buffered duty.
  int unsigned pre_tab [2] = '{1, 4};
  int unsigned k_m     [2] = '{0, 0};
  int unsigned dact_m  [2] = '{0, 0};

  always #5 sysclk = ~sysclk;

  pwm_pulse_generator #(.PRESCALE(1), .PRESCALE_W(8)) dut0 (
    .sysclk (sysclk), .reset (reset), .enable (enable), .duty_in (duty_in),
    .pwm_out (pwm0), .period_start (ps0), .duty_active (da0)
  );

  pwm_pulse_generator #(.PRESCALE(4), .PRESCALE_W(8)) dut1 (
    .sysclk (sysclk), .reset (reset), .enable (enable), .duty_in (duty_in),
    .pwm_out (pwm1), .period_start (ps1), .duty_active (da1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int unsigned sat(input int unsigned d);
    return (d > 64) ? 64 : d;
  endfunction

  // Apply one clock edge with current inputs, advance the model and compare outputs.
  task automatic cycle();
    logic        e_pwm [2];
    logic        e_ps  [2];
    int unsigned per, pos;
    for (int i = 0; i < 2; i++) begin
      per = 64 * pre_tab[i];
      e_pwm[i] = 1'b0;
      e_ps[i]  = 1'b0;
      if (reset) begin
        k_m[i] = 0;
        dact_m[i] = 0;
      end else if (!enable) begin
        k_m[i] = 0;
        dact_m[i] = sat(32'(duty_in));
      end else begin
        pos = k_m[i] % per;
        e_pwm[i] = ((pos / pre_tab[i]) < dact_m[i]);
        e_ps[i]  = (pos == 0);
        if (pos == per - 1) dact_m[i] = sat(32'(duty_in));
        k_m[i]++;
      end
    end
    @(posedge sysclk);
    #1;
    cyc++;
    check("p1_pwm_out",      32'(pwm0), 32'(e_pwm[0]));
    check("p1_period_start", 32'(ps0),  32'(e_ps[0]));
    check("p1_duty_active",  32'(da0),  dact_m[0]);
    check("p4_pwm_out",      32'(pwm1), 32'(e_pwm[1]));
    check("p4_period_start", 32'(ps1),  32'(e_ps[1]));
    check("p4_duty_active",  32'(da1),  dact_m[1]);
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  // Count high cycles of the prescale-1 output over one full period starting at a strobe.
  task automatic count_period(input int unsigned exp_high);
    int unsigned highs = 0;
    int unsigned guard = 0;
    while (ps0 !== 1'b1 && guard < 200) begin
      cycle();
      guard++;
    end
    check("p1_strobe_found", 32'(ps0), 32'd1);
    for (int unsigned i = 0; i < 64; i++) begin
      if (pwm0 === 1'b1) highs++;
      cycle();
    end
    check("p1_high_count", highs, exp_high);
  endtask

  initial begin
    #2;
    // Reset, then one disabled cycle so duty_active tracks the input before enabling.
    reset = 1'b1; enable = 1'b0; duty_in = 7'd32;
    run(3);
    reset = 1'b0;
    run(1);
    enable = 1'b1;
    count_period(32);
    run(200);

    // Duty extremes and saturation.
    duty_in = 7'd0;   run(800);
    duty_in = 7'd64;  run(800);
    duty_in = 7'd100; run(800);
    count_period(64);

    // Mid-period duty change only takes effect at the next wrap.
    duty_in = 7'd16; run(300);
    duty_in = 7'd48; run(600);
    count_period(48);

    // Minimum non-zero duty.
    duty_in = 7'd1; run(600);

    // Reset pulse mid-period with enable held high.
    duty_in = 7'd40; run(300);
    reset = 1'b1; run(1);
    reset = 1'b0; run(600);

    // Disable mid-period, change duty, re-enable.
    run(37);
    enable = 1'b0; run(20);
    duty_in = 7'd8; run(1);
    enable = 1'b1;
    count_period(8);
    run(400);

    // Random phase: sporadic duty changes, enable toggles and reset pulses.
    for (int unsigned i = 0; i < 4000; i++) begin
      if ($urandom_range(63) == 0) duty_in = 7'($urandom_range(127));
      if ($urandom_range(299) == 0) enable = ~enable;
      reset = ($urandom_range(499) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
